shape_color_classifier: RTL
===========================

# shape_color_classifier

Per-frame treasure classifier on the camera pixel stream. It counts red and blue pixels over the full frame and samples per-row object widths on configurable rows. At frame end it decides the colour and the shape (square / triangle / diamond / other). It publishes a result only after the same classification is seen on `CONFIRM_FRAMES` consecutive frames. It sits between the camera downsampler/VGA coordinate generator and the Arduino result interface, and is a parametrised successor to the single-frame colour/shape detector.

## Interface
**Parameters**
- `SCREEN_WIDTH`, default 176: active pixels per line.
- `SCREEN_HEIGHT`, default 144: active lines per frame.
- `X_MARGIN`, default 20: width counting is limited to `X_MARGIN < X < SCREEN_WIDTH-X_MARGIN`.
- `ROW_TOP` / `ROW_MID` / `ROW_BOT`, defaults 28 / 72 / 116: sampled rows.
- `COLOR_THRESH`, default 3000: minimum pixel count needed to declare a colour.
- `TOL_SHIFT`, default 3: square tolerance is `count >> TOL_SHIFT`.
- `CONFIRM_FRAMES`, default 2: number of identical consecutive frames before publishing (≥1).
- `CNT_W`, default 15: width of the frame pixel counters.

**Ports**
- `CLK` in 1: pixel clock.
- `RST_N` in 1: asynchronous, active-low reset.
- `PIXEL_IN` in 8: RGB332 pixel.
- `VGA_PIXEL_X`, `VGA_PIXEL_Y` in 10: coordinate of `PIXEL_IN`.
- `VGA_VSYNC_NEG` in 1: low during vertical sync, high during the active frame.
- `RESULT` out 8: confirmed result. [1:0] colour (01 red, 10 blue, 00 none); [4:2] shape (001 diamond, 010 triangle, 011 square, 100 other, 000 none); [7:5] are 0.
- `RESULT_VALID` out 1: one-cycle pulse when `RESULT` is (re)published.
- `red_count`, `blue_count` out `CNT_W`: frame pixel counters, for debug.
- `row_top`, `row_mid`, `row_bot` out 10: widths of the winning colour from the last evaluation.

## Operation
- **Pixel classes**
  - Red: `PIXEL_IN[7:5]≥1 && PIXEL_IN[4:3]==0 && PIXEL_IN[1:0]==0`.
  - Blue: `PIXEL_IN[7:6]==0 && PIXEL_IN[4]==0`.
  - A pixel may be both red and blue; it then counts in both.
- **Pixel uniqueness**
  - A pixel is counted only on the first cycle its (X,Y) differs from the previous cycle's registered (X,Y).
  - Repeated coordinates are ignored.
  - The window is `X<SCREEN_WIDTH && Y<SCREEN_HEIGHT`.
- **Counters**
  - The frame counters and six row counters (red and blue × top/mid/bot) saturate at all-ones and never wrap.
  - A row counter increments only when Y equals its row, X is inside the margin window, and the pixel has the matching class.
- **FSM** (state register cleared by `RST_N`)
  - `IDLE`: wait for a rising edge of `VGA_VSYNC_NEG`. A falling edge seen in `IDLE` is ignored, so a partial frame after reset is discarded.
  - `ACCUM`: entered on the rising edge; all counters clear on that same clock. Counting runs until a falling edge, then go to `EVAL`.
  - `EVAL` (1 cycle):
    - Colour: red if `red_count > COLOR_THRESH`, else blue if `blue_count > COLOR_THRESH`, else none. Red wins if both exceed the threshold.
    - Load `f/s/t` from the winning colour's row counters into `row_*`.
    - Shape: none if the colour is none or any of f/s/t is 0. Otherwise:
      - square if `|s−f| ≤ s>>TOL_SHIFT` and `|t−s| ≤ t>>TOL_SHIFT`;
      - else triangle if `s<t`;
      - else diamond if `s>t`;
      - else other.
    - Form the candidate byte, then go to `VOTE`.
  - `VOTE` (1 cycle):
    - If the candidate equals the last candidate, `streak` increments, saturating at `CONFIRM_FRAMES`. Otherwise `last←candidate` and `streak←1`.
    - If `streak` (post-update) equals `CONFIRM_FRAMES` and the candidate differs from `RESULT` or this is the first confirmation after reset: `RESULT←candidate` and pulse `RESULT_VALID`.
    - Go to `IDLE`.
- **Counter hold**: `red_count` and `blue_count` hold their end-of-frame values until the next rising edge.

## Timing
- **Reset values**: `RESULT=0`, `RESULT_VALID=0`, all counters 0, `row_*=0`, `last=0`, `streak=0`, state `IDLE`.
- **Reset mid-frame** (asynchronous): everything returns to reset values immediately. Counting resumes only after the next rising edge of `VGA_VSYNC_NEG`.
- **Edge detection**: uses one registered copy of `VGA_VSYNC_NEG`.
- **Counter clear**: counters are 0 on the clock after the edge where high is first sampled. The pixel on that same cycle is not counted.
- **Evaluation latency**:
  - Edge N: low first sampled, state becomes `EVAL`.
  - Edge N+1: `row_*` registered, state becomes `VOTE`.
  - Edge N+2: `RESULT` updated and `RESULT_VALID` high for exactly one cycle.
- **Short sync**: a rising edge arriving during `EVAL` or `VOTE` is missed, and that frame is skipped.
- **Arithmetic**: widths are 10-bit; differences are absolute and unsigned.

## Test plan
All frames use background `0xFF`, which is neither red nor blue.
- **Red square**: red `0xE0` square at X 60–99, Y 20–124, two frames → after frame 1 no pulse; after frame 2 `RESULT=0x0D`, one-cycle `RESULT_VALID`, `row_*=40/40/40`, `red_count=4200`.
- **Blue triangle**: blue `0x03` triangle with width 20/60/100 at rows 28/72/116 (>3000 px), two frames → `RESULT=0x0A`. A third identical frame → no new pulse.
- **Blue diamond**: blue diamond with widths 20/110/20 → `RESULT=0x06`. Then an empty frame ×2 → `RESULT=0x00` with a pulse.
- **Alternating results**: red square, blue triangle, red square, … → `streak` never reaches 2, no pulses, `RESULT` unchanged.
- **Pixel repeats**: red square frame with every coordinate held 2 cycles → counts identical to the single-cycle case (`red_count=4200`).
- **Reset mid-frame**: assert `RST_N` low at Y=70 during frame 2 of the red square → outputs zero at once. The next two full frames are needed before `0x0D` appears. A falling edge before any rising edge is ignored.

Source files
------------

// File: rtl/shape_color_classifier.sv
// Per-frame treasure classifier: counts red/blue pixels, samples object widths on three rows,
// decides colour and shape at frame end and publishes only after CONFIRM_FRAMES agreeing frames.
module shape_color_classifier #(
  parameter int unsigned SCREEN_WIDTH   = 176,
  parameter int unsigned SCREEN_HEIGHT  = 144,
  parameter int unsigned X_MARGIN       = 20,
  parameter int unsigned ROW_TOP        = 28,
  parameter int unsigned ROW_MID        = 72,
  parameter int unsigned ROW_BOT        = 116,
  parameter int unsigned COLOR_THRESH   = 3000,
  parameter int unsigned TOL_SHIFT      = 3,
  parameter int unsigned CONFIRM_FRAMES = 2,
  parameter int unsigned CNT_W          = 15
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [7:0]       PIXEL_IN,
  input  logic [9:0]       VGA_PIXEL_X,
  input  logic [9:0]       VGA_PIXEL_Y,
  input  logic             VGA_VSYNC_NEG,
  output logic [7:0]       RESULT,
  output logic             RESULT_VALID,
  output logic [CNT_W-1:0] red_count,
  output logic [CNT_W-1:0] blue_count,
  output logic [9:0]       row_top,
  output logic [9:0]       row_mid,
  output logic [9:0]       row_bot
);
  localparam int unsigned SW = $clog2(CONFIRM_FRAMES + 1);

  typedef enum logic [1:0] {StIdle, StAccum, StEval, StVote} state_e;

  state_e           state_q, state_d;
  logic             vsync_q;
  logic [9:0]       x_q, y_q;
  logic [CNT_W-1:0] red_cnt_q, red_cnt_d, blue_cnt_q, blue_cnt_d;
  logic [9:0]       red_row_q [3];
  logic [9:0]       red_row_d [3];
  logic [9:0]       blue_row_q [3];
  logic [9:0]       blue_row_d [3];
  logic [9:0]       row_q [3];
  logic [9:0]       row_d [3];
  logic [7:0]       cand_q, cand_d, last_q, last_d, result_q, result_d;
  logic [SW-1:0]    streak_q, streak_d, streak_nxt;
  logic             valid_q, valid_d, confirmed_q, confirmed_d;

  logic       rise, fall, is_red, is_blue, fresh, in_win, in_margin, count_en, publish;
  logic       pick_red, pick_blue;
  logic [9:0] row_y [3];
  logic [9:0] f, s, t, d_sf, d_ts;
  logic [2:0] shape;

  function automatic logic [CNT_W-1:0] inc_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [9:0] inc_row(input logic [9:0] v);
    return (&v) ? v : v + 10'd1;
  endfunction

  assign row_y[0] = 10'(ROW_TOP);
  assign row_y[1] = 10'(ROW_MID);
  assign row_y[2] = 10'(ROW_BOT);

  assign rise      = VGA_VSYNC_NEG & ~vsync_q;
  assign fall      = ~VGA_VSYNC_NEG & vsync_q;
  assign is_red    = (PIXEL_IN[7:5] != 3'd0) && (PIXEL_IN[4:3] == 2'd0) && (PIXEL_IN[1:0] == 2'd0);
  assign is_blue   = (PIXEL_IN[7:6] == 2'd0) && !PIXEL_IN[4];
  assign fresh     = (VGA_PIXEL_X != x_q) || (VGA_PIXEL_Y != y_q);
  assign in_win    = (VGA_PIXEL_X < 10'(SCREEN_WIDTH)) && (VGA_PIXEL_Y < 10'(SCREEN_HEIGHT));
  assign in_margin = (VGA_PIXEL_X > 10'(X_MARGIN)) && (VGA_PIXEL_X < 10'(SCREEN_WIDTH - X_MARGIN));
  assign count_en  = (state_q == StAccum) && !fall && fresh && in_win;

  // Frame decision, evaluated from the held end-of-frame counters.
  always_comb begin
    pick_red  = red_cnt_q > CNT_W'(COLOR_THRESH);
    pick_blue = !pick_red && (blue_cnt_q > CNT_W'(COLOR_THRESH));
    f = pick_red ? red_row_q[0] : blue_row_q[0];
    s = pick_red ? red_row_q[1] : blue_row_q[1];
    t = pick_red ? red_row_q[2] : blue_row_q[2];
    d_sf = (s >= f) ? s - f : f - s;
    d_ts = (t >= s) ? t - s : s - t;
    shape = 3'b000;
    if ((pick_red || pick_blue) && f != '0 && s != '0 && t != '0) begin
      if (d_sf <= (s >> TOL_SHIFT) && d_ts <= (t >> TOL_SHIFT)) shape = 3'b011;
      else if (s < t) shape = 3'b010;
      else if (s > t) shape = 3'b001;
      else shape = 3'b100;
    end
  end

  always_comb begin
    streak_nxt = (cand_q != last_q) ? SW'(1) :
                 (streak_q == SW'(CONFIRM_FRAMES)) ? streak_q : streak_q + SW'(1);
    publish = (streak_nxt == SW'(CONFIRM_FRAMES)) && ((cand_q != result_q) || !confirmed_q);
  end

  always_comb begin
    state_d     = state_q;
    red_cnt_d   = red_cnt_q;
    blue_cnt_d  = blue_cnt_q;
    red_row_d   = red_row_q;
    blue_row_d  = blue_row_q;
    row_d       = row_q;
    cand_d      = cand_q;
    last_d      = last_q;
    streak_d    = streak_q;
    result_d    = result_q;
    confirmed_d = confirmed_q;
    valid_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d    = StAccum;
          red_cnt_d  = '0;
          blue_cnt_d = '0;
          red_row_d  = '{default: '0};
          blue_row_d = '{default: '0};
        end
      end
      StAccum: begin
        if (fall) begin
          state_d = StEval;
        end else if (count_en) begin
          if (is_red) red_cnt_d = inc_cnt(red_cnt_q);
          if (is_blue) blue_cnt_d = inc_cnt(blue_cnt_q);
          for (int i = 0; i < 3; i++) begin
            if (VGA_PIXEL_Y == row_y[i] && in_margin) begin
              if (is_red) red_row_d[i] = inc_row(red_row_q[i]);
              if (is_blue) blue_row_d[i] = inc_row(blue_row_q[i]);
            end
          end
        end
      end
      StEval: begin
        row_d[0] = f;
        row_d[1] = s;
        row_d[2] = t;
        cand_d   = {3'b000, shape, pick_blue, pick_red};
        state_d  = StVote;
      end
      StVote: begin
        last_d   = cand_q;
        streak_d = streak_nxt;
        if (publish) begin
          result_d    = cand_q;
          valid_d     = 1'b1;
          confirmed_d = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // vsync_q resets high so a frame already in progress at reset never looks like a rising edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= StIdle;
      vsync_q     <= 1'b1;
      x_q         <= '0;
      y_q         <= '0;
      red_cnt_q   <= '0;
      blue_cnt_q  <= '0;
      red_row_q   <= '{default: '0};
      blue_row_q  <= '{default: '0};
      row_q       <= '{default: '0};
      cand_q      <= '0;
      last_q      <= '0;
      streak_q    <= '0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      confirmed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= VGA_VSYNC_NEG;
      x_q         <= VGA_PIXEL_X;
      y_q         <= VGA_PIXEL_Y;
      red_cnt_q   <= red_cnt_d;
      blue_cnt_q  <= blue_cnt_d;
      red_row_q   <= red_row_d;
      blue_row_q  <= blue_row_d;
      row_q       <= row_d;
      cand_q      <= cand_d;
      last_q      <= last_d;
      streak_q    <= streak_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      confirmed_q <= confirmed_d;
    end
  end

  assign RESULT       = result_q;
  assign RESULT_VALID = valid_q;
  assign red_count    = red_cnt_q;
  assign blue_count   = blue_cnt_q;
  assign row_top      = row_q[0];
  assign row_mid      = row_q[1];
  assign row_bot      = row_q[2];

endmodule
